// File: rtl/bridge_axi4lite_ccx.sv
// AXI4-Lite subordinate that replays one AXI read or write at a time as a single CCX memory request.
// Optional REQ-phase grant timeout is enabled with `define BRIDGE_AXI_CCX_TIMEOUT_EN.
module bridge_axi4lite_ccx #(
  parameter int AW      = 39,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            axi_aclk,
  input  logic            axi_areset,
  input  logic            axi_awvalid,
  output logic            axi_awready,
  input  logic [AW-1:0]   axi_awaddr,
  input  logic [2:0]      axi_awprot,
  input  logic            axi_wvalid,
  output logic            axi_wready,
  input  logic [DW-1:0]   axi_wdata,
  input  logic [DW/8-1:0] axi_wstrb,
  output logic            axi_bvalid,
  input  logic            axi_bready,
  output logic [1:0]      axi_bresp,
  input  logic            axi_arvalid,
  output logic            axi_arready,
  input  logic [AW-1:0]   axi_araddr,
  input  logic [2:0]      axi_arprot,
  output logic            axi_rvalid,
  input  logic            axi_rready,
  output logic [DW-1:0]   axi_rdata,
  output logic [1:0]      axi_rresp,
  output logic            ccx_req,
  output logic            ccx_rtype,
  output logic [AW-1:0]   ccx_addr,
  output logic            ccx_wen,
  output logic [DW/8-1:0] ccx_strb,
  output logic [DW-1:0]   ccx_wdata,
  input  logic            ccx_gnt,
  input  logic            ccx_err,
  input  logic [DW-1:0]   ccx_rdata
);

  localparam int SW = DW / 8;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range_check
    $error("TIMEOUT must lie in 1..255");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e          state_q, state_d;
  logic            aw_held_q, aw_held_d;
  logic            w_held_q, w_held_d;
  logic            last_rd_q, last_rd_d;
  logic            is_rd_q, is_rd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      prot_q, prot_d;
  logic [SW-1:0]   strb_q, strb_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      resp_q, resp_d;
`ifdef BRIDGE_AXI_CCX_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  logic [7:0]      cnt_q, cnt_d;
`endif

  logic idle, rd_sel, ar_hs, aw_hs, w_hs;

  // A half-captured write blocks reads; otherwise a collision goes to the side not served last.
  assign idle   = (state_q == IDLE);
  assign rd_sel = axi_arvalid & ~aw_held_q & ~w_held_q &
                  (~(axi_awvalid | axi_wvalid) | ~last_rd_q);

  assign axi_awready = idle & ~aw_held_q & ~rd_sel & ~axi_areset;
  assign axi_wready  = idle & ~w_held_q  & ~rd_sel & ~axi_areset;
  assign axi_arready = idle & ~aw_held_q & ~w_held_q & rd_sel & ~axi_areset;

  assign ar_hs = axi_arvalid & axi_arready;
  assign aw_hs = axi_awvalid & axi_awready;
  assign w_hs  = axi_wvalid  & axi_wready;

  assign ccx_req   = (state_q == REQ);
  assign ccx_rtype = ~prot_q[2];
  assign ccx_addr  = addr_q;
  assign ccx_wen   = ~is_rd_q;
  assign ccx_strb  = is_rd_q ? '0 : strb_q;
  assign ccx_wdata = wdata_q;

  assign axi_rvalid = (state_q == RESP) & is_rd_q;
  assign axi_bvalid = (state_q == RESP) & ~is_rd_q;
  assign axi_rdata  = rdata_q;
  assign axi_rresp  = resp_q;
  assign axi_bresp  = resp_q;

  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    last_rd_d = last_rd_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    prot_d    = prot_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
`ifdef BRIDGE_AXI_CCX_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef BRIDGE_AXI_CCX_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (ar_hs) begin
          addr_d    = axi_araddr;
          prot_d    = axi_arprot;
          is_rd_d   = 1'b1;
          last_rd_d = 1'b1;
          state_d   = REQ;
        end else begin
          if (aw_hs) begin
            addr_d    = axi_awaddr;
            prot_d    = axi_awprot;
            aw_held_d = 1'b1;
            last_rd_d = 1'b0;
          end
          if (w_hs) begin
            wdata_d  = axi_wdata;
            strb_d   = axi_wstrb;
            w_held_d = 1'b1;
          end
          // Launch as soon as both halves are in, even when the last arrives this cycle.
          if ((aw_held_q | aw_hs) & (w_held_q | w_hs)) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            is_rd_d   = 1'b0;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        if (ccx_gnt) begin
          resp_d  = ccx_err ? 2'b10 : 2'b00;
          if (is_rd_q) rdata_d = ccx_rdata;
          state_d = RESP;
        end
`ifdef BRIDGE_AXI_CCX_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          resp_d  = 2'b10;
          if (is_rd_q) rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        if (is_rd_q ? axi_rready : axi_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q   <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      last_rd_q <= 1'b0;
      is_rd_q   <= 1'b1;
      addr_q    <= '0;
      prot_q    <= '0;
      strb_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
`ifdef BRIDGE_AXI_CCX_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      last_rd_q <= last_rd_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      prot_q    <= prot_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
`ifdef BRIDGE_AXI_CCX_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_bridge_axi4lite_ccx.sv
// Self-checking bench for bridge_axi4lite_ccx: table of transactions, CCX responder model and
// response scoreboard, plus hand-written collision, stall, reset and timeout sequences.
module tb_bridge_axi4lite_ccx;
  localparam int AW = 39;
  localparam int DW = 64;
  localparam int SW = 8;
`ifdef BRIDGE_AXI_CCX_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          axi_awvalid = 0, axi_awready;
  logic [AW-1:0] axi_awaddr = '0;
  logic [2:0]    axi_awprot = '0;
  logic          axi_wvalid = 0, axi_wready;
  logic [DW-1:0] axi_wdata = '0;
  logic [SW-1:0] axi_wstrb = '0;
  logic          axi_bvalid, axi_bready = 1;
  logic [1:0]    axi_bresp;
  logic          axi_arvalid = 0, axi_arready;
  logic [AW-1:0] axi_araddr = '0;
  logic [2:0]    axi_arprot = '0;
  logic          axi_rvalid, axi_rready = 1;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          ccx_req, ccx_rtype, ccx_wen;
  logic [AW-1:0] ccx_addr;
  logic [SW-1:0] ccx_strb;
  logic [DW-1:0] ccx_wdata;
  logic          ccx_gnt = 0, ccx_err = 0;
  logic [DW-1:0] ccx_rdata = '0;

  bridge_axi4lite_ccx #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .ccx_req(ccx_req), .ccx_rtype(ccx_rtype), .ccx_addr(ccx_addr), .ccx_wen(ccx_wen),
    .ccx_strb(ccx_strb), .ccx_wdata(ccx_wdata), .ccx_gnt(ccx_gnt), .ccx_err(ccx_err), .ccx_rdata(ccx_rdata)
  );

  // gdly < 0 means the responder never grants.
  typedef struct {
    logic          wr;
    logic          wfirst;
    logic [AW-1:0] addr;
    logic [2:0]    prot;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            gdly;
    logic          err;
    logic [DW-1:0] rdata;
  } txn_t;

  typedef struct {
    logic          wr;
    logic [1:0]    resp;
    logic [DW-1:0] data;
  } resp_t;

  txn_t  ccxQ[$];
  resp_t respQ[$];
  txn_t  ct;
  resp_t mr;
  txn_t  vec[6];
  int    checks = 0;
  int    failures = 0;
  int    reqCycles = 0;

  function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void expectTxn(input txn_t t, input logic withResp);
    resp_t r;
    ccxQ.push_back(t);
    r.wr   = t.wr;
    r.resp = t.err ? 2'b10 : 2'b00;
    r.data = t.rdata;
    if (t.gdly < 0) begin
      r.resp = 2'b10;
      r.data = '0;
    end
    if (withResp) respQ.push_back(r);
  endfunction

  // CCX responder: checks the request against the expected transaction, then grants.
  initial begin
    forever begin
      @(negedge clk);
      if (ccx_req && !rst) begin
        if (ccxQ.size() == 0) begin
          checkOutput("ccx_unexpected_req", 64'(ccx_req), 64'd0);
          while (ccx_req) @(negedge clk);
        end else begin
          ct = ccxQ.pop_front();
          checkOutput("ccx_addr", 64'(ccx_addr), 64'(ct.addr));
          checkOutput("ccx_wen", 64'(ccx_wen), 64'(ct.wr));
          checkOutput("ccx_rtype", 64'(ccx_rtype), 64'(!ct.prot[2]));
          checkOutput("ccx_strb", 64'(ccx_strb), ct.wr ? 64'(ct.strb) : 64'd0);
          if (ct.wr) checkOutput("ccx_wdata", ccx_wdata, ct.wdata);
          reqCycles = 1;
          if (ct.gdly < 0) begin
            while (ccx_req && reqCycles < 1000) begin
              @(negedge clk);
              if (ccx_req) reqCycles++;
            end
          end else begin
            for (int i = 0; i < ct.gdly; i++) begin
              @(negedge clk);
              checkOutput("ccx_req_hold", 64'(ccx_req), 64'd1);
            end
            ccx_gnt = 1'b1;
            ccx_err = ct.err;
            ccx_rdata = ct.rdata;
            @(negedge clk);
            ccx_gnt = 1'b0;
            ccx_err = 1'b0;
            ccx_rdata = ~ct.rdata;
            checkOutput("ccx_req_drop", 64'(ccx_req), 64'd0);
          end
        end
      end
    end
  end

  // Response scoreboard.
  always @(negedge clk) begin
    if (!rst && ((axi_rvalid && axi_rready) || (axi_bvalid && axi_bready))) begin
      if (respQ.size() == 0) begin
        checkOutput("resp_unexpected", 64'(axi_rvalid | axi_bvalid), 64'd0);
      end else begin
        mr = respQ.pop_front();
        checkOutput("resp_kind_rd", 64'(axi_rvalid), 64'(!mr.wr));
        checkOutput("resp_kind_wr", 64'(axi_bvalid), 64'(mr.wr));
        if (mr.wr) begin
          checkOutput("bresp", 64'(axi_bresp), 64'(mr.resp));
        end else begin
          checkOutput("rresp", 64'(axi_rresp), 64'(mr.resp));
          checkOutput("rdata", axi_rdata, mr.data);
        end
      end
    end
  end

  // Drives one valid until its ready is seen, then drops it after the handshake edge.
  task automatic handshake(input int ch);
    int   n = 0;
    logic got = 1'b0;
    case (ch)
      0: axi_arvalid = 1'b1;
      1: axi_awvalid = 1'b1;
      default: axi_wvalid = 1'b1;
    endcase
    while (!got && n < 500) begin
      @(negedge clk);
      case (ch)
        0: got = axi_arready;
        1: got = axi_awready;
        default: got = axi_wready;
      endcase
      n++;
    end
    checkOutput(ch == 0 ? "ar_handshake" : (ch == 1 ? "aw_handshake" : "w_handshake"), 64'(got), 64'd1);
    @(posedge clk);
    #1;
    case (ch)
      0: axi_arvalid = 1'b0;
      1: axi_awvalid = 1'b0;
      default: axi_wvalid = 1'b0;
    endcase
  endtask

  task automatic axiRead(input txn_t t);
    axi_araddr = t.addr;
    axi_arprot = t.prot;
    handshake(0);
  endtask

  task automatic axiWrite(input txn_t t);
    axi_awaddr = t.addr;
    axi_awprot = t.prot;
    axi_wdata  = t.wdata;
    axi_wstrb  = t.strb;
    if (t.wfirst) begin
      handshake(2);
      for (int i = 0; i < 3; i++) begin
        checkOutput("wfirst_no_req", 64'(ccx_req), 64'd0);
        checkOutput("wfirst_wready_low", 64'(axi_wready), 64'd0);
        @(posedge clk);
        #1;
      end
      handshake(1);
    end else begin
      fork
        handshake(1);
        handshake(2);
      join
    end
  endtask

  task automatic applyStimulus(input txn_t t);
    expectTxn(t, 1'b1);
    if (t.wr) axiWrite(t);
    else axiRead(t);
  endtask

  task automatic drain();
    int n = 0;
    while ((respQ.size() != 0 || ccxQ.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 64'(respQ.size() + ccxQ.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    txn_t c0, c1, c2, s0, s1, rr, fr;
    int   n;

    vec[0] = '{1'b0, 1'b0, 39'h100, 3'd0, 64'd0, 8'h00, 2, 1'b0, 64'hDEADBEEF_CAFEF00D};
    vec[1] = '{1'b1, 1'b1, 39'h2000, 3'd0, 64'h11223344_55667788, 8'h0F, 1, 1'b1, 64'd0};
    vec[2] = '{1'b0, 1'b0, 39'h7F_FFFF_FFF8, 3'd4, 64'd0, 8'h00, 0, 1'b1, 64'h01234567_89ABCDEF};
    vec[3] = '{1'b1, 1'b0, 39'h40, 3'd4, 64'hA5A5A5A5_5A5A5A5A, 8'hFF, 0, 1'b0, 64'd0};
    vec[4] = '{1'b1, 1'b0, 39'h7F_FFFF_FFFF, 3'd2, 64'hFEDCBA98_76543210, 8'h80, 3, 1'b0, 64'd0};
    vec[5] = '{1'b0, 1'b0, 39'h0, 3'd1, 64'd0, 8'h00, 5, 1'b0, 64'hFFFFFFFF_FFFFFFFF};

    c0 = '{1'b0, 1'b0, 39'h300, 3'd0, 64'd0, 8'h00, 1, 1'b0, 64'h0000_1111_2222_3333};
    c1 = '{1'b1, 1'b0, 39'h400, 3'd0, 64'h4444_5555_6666_7777, 8'h3C, 1, 1'b0, 64'd0};
    c2 = '{1'b0, 1'b0, 39'h500, 3'd4, 64'd0, 8'h00, 0, 1'b0, 64'h8888_9999_AAAA_BBBB};
    s0 = '{1'b0, 1'b0, 39'h600, 3'd0, 64'd0, 8'h00, 0, 1'b0, 64'h0F0F_0F0F_F0F0_F0F0};
    s1 = '{1'b0, 1'b0, 39'h608, 3'd0, 64'd0, 8'h00, 1, 1'b0, 64'h1357_9BDF_2468_ACE0};
    rr = '{1'b0, 1'b0, 39'h700, 3'd0, 64'd0, 8'h00, -1, 1'b0, 64'd0};
    fr = '{1'b0, 1'b0, 39'h708, 3'd0, 64'd0, 8'h00, 1, 1'b0, 64'hC0DE_C0DE_1234_5678};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_awready", 64'(axi_awready), 64'd0);
    checkOutput("reset_wready", 64'(axi_wready), 64'd0);
    checkOutput("reset_arready", 64'(axi_arready), 64'd0);
    checkOutput("reset_rvalid", 64'(axi_rvalid), 64'd0);
    checkOutput("reset_bvalid", 64'(axi_bvalid), 64'd0);
    checkOutput("reset_ccx_req", 64'(ccx_req), 64'd0);
    checkOutput("reset_rdata", axi_rdata, 64'd0);
    checkOutput("reset_rresp", 64'(axi_rresp), 64'd0);
    checkOutput("reset_bresp", 64'(axi_bresp), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Collision right after reset: read first, then the pending write beats a fresh read.
    expectTxn(c0, 1'b1);
    expectTxn(c1, 1'b1);
    expectTxn(c2, 1'b1);
    fork
      begin
        axiRead(c0);
        axiRead(c2);
      end
      axiWrite(c1);
    join
    drain();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vec[i]);
      drain();
    end

    // Read data stall: response must stay put and the next read must wait.
    axi_rready = 1'b0;
    expectTxn(s0, 1'b1);
    expectTxn(s1, 1'b1);
    axiRead(s0);
    fork
      axiRead(s1);
      begin
        n = 0;
        while (!axi_rvalid && n < 100) begin
          @(negedge clk);
          n++;
        end
        checkOutput("stall_rvalid_seen", 64'(axi_rvalid), 64'd1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput("stall_rvalid", 64'(axi_rvalid), 64'd1);
          checkOutput("stall_rdata", axi_rdata, s0.rdata);
          checkOutput("stall_arready", 64'(axi_arready), 64'd0);
        end
        @(posedge clk);
        #1 axi_rready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset while a request is outstanding.
    expectTxn(rr, 1'b0);
    axiRead(rr);
    @(negedge clk);
    checkOutput("pre_reset_req", 64'(ccx_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_req", 64'(ccx_req), 64'd0);
    checkOutput("async_reset_rvalid", 64'(axi_rvalid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(fr);
    drain();

`ifdef BRIDGE_AXI_CCX_TIMEOUT_EN
    expectTxn(rr, 1'b1);
    axiRead(rr);
    drain();
    checkOutput("timeout_req_cycles", 64'(reqCycles), 64'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
